// File: rtl/beta_useq.sv
`default_nettype none
// ============================================================================
// Module   : beta_useq
// Brief    : Multi-cycle micro-sequencer: fetch into IR, step micro-program,
//            own the PC and latch a sticky trap on illegal conditions.
// Revision : 1.0
// ============================================================================
module beta_useq #(
    parameter int unsigned          XLEN     = 32,
    parameter int unsigned          USTEP_W  = 4,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    output logic                    imem_req_o,
    output logic [XLEN-1:0]         imem_addr_o,
    input  logic                    imem_gnt_i,
    input  logic                    imem_rvalid_i,
    input  logic [XLEN-1:0]         imem_rdata_i,
    output logic [XLEN-1:0]         ir_o,
    output logic [XLEN-1:0]         pc_o,
    input  logic [8:0]              cu_addr_i,
    input  logic                    invalid_i,
    output logic [9+USTEP_W-1:0]    urom_addr_o,
    output logic                    exec_o,
    input  logic                    uw_last_i,
    input  logic                    uw_mem_i,
    input  logic                    dmem_done_i,
    input  logic                    pc_load_i,
    input  logic [XLEN-1:0]         pc_target_i,
    output logic                    trap_o,
    output logic [1:0]              trap_cause_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_FWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [XLEN-1:0] C_NOP          = XLEN'(32'h0000_0013);
    localparam logic [1:0]      C_CAUSE_NONE   = 2'd0;
    localparam logic [1:0]      C_CAUSE_ILL    = 2'd1;
    localparam logic [1:0]      C_CAUSE_ALIGN  = 2'd2;
    localparam logic [1:0]      C_CAUSE_RUNAWY = 2'd3;

    state_t                 r_state;
    logic [XLEN-1:0]        r_pc;
    logic [XLEN-1:0]        r_ir;
    logic [8:0]             r_cu_addr;
    logic [USTEP_W-1:0]     r_ustep;
    logic [1:0]             r_cause;

    state_t                 w_state_nxt;
    logic [XLEN-1:0]        w_pc_nxt;
    logic [XLEN-1:0]        w_ir_nxt;
    logic [8:0]             w_cu_addr_nxt;
    logic [USTEP_W-1:0]     w_ustep_nxt;
    logic [1:0]             w_cause_nxt;

    logic                   w_stall;
    logic                   w_misalign;
    logic                   w_ustep_max;
    logic [XLEN-1:0]        w_pc_plus4;

    assign w_stall     = uw_mem_i & ~dmem_done_i;
    assign w_misalign  = pc_load_i & (pc_target_i[1:0] != 2'b00);
    assign w_ustep_max = (r_ustep == {USTEP_W{1'b1}});
    assign w_pc_plus4  = r_pc + XLEN'(4);

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_ir_nxt      = r_ir;
        w_cu_addr_nxt = r_cu_addr;
        w_ustep_nxt   = r_ustep;
        w_cause_nxt   = r_cause;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_gnt_i) begin
                    w_state_nxt = S_FWAIT;
                end
            end
            S_FWAIT: begin
                if (imem_rvalid_i) begin
                    w_ir_nxt    = imem_rdata_i;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_cu_addr_nxt = cu_addr_i;
                w_ustep_nxt   = '0;
                if (invalid_i) begin
                    w_cause_nxt = C_CAUSE_ILL;
                    w_state_nxt = S_TRAP;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                // A stalled micro-word neither advances nor retires, even if last.
                if (!w_stall) begin
                    if (uw_last_i) begin
                        if (w_misalign) begin
                            w_cause_nxt = C_CAUSE_ALIGN;
                            w_state_nxt = S_TRAP;
                        end else begin
                            w_pc_nxt    = pc_load_i ? pc_target_i : w_pc_plus4;
                            w_state_nxt = S_FETCH;
                        end
                    end else if (w_ustep_max) begin
                        w_cause_nxt = C_CAUSE_RUNAWY;
                        w_state_nxt = S_TRAP;
                    end else begin
                        w_ustep_nxt = r_ustep + USTEP_W'(1);
                    end
                end
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= C_NOP;
            r_cu_addr <= '0;
            r_ustep   <= '0;
            r_cause   <= C_CAUSE_NONE;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_ir      <= w_ir_nxt;
            r_cu_addr <= w_cu_addr_nxt;
            r_ustep   <= w_ustep_nxt;
            r_cause   <= w_cause_nxt;
        end
    end

    assign imem_req_o   = (r_state == S_FETCH);
    assign imem_addr_o  = r_pc;
    assign ir_o         = r_ir;
    assign pc_o         = r_pc;
    assign urom_addr_o  = {r_cu_addr, r_ustep};
    assign exec_o       = (r_state == S_EXEC);
    assign trap_o       = (r_state == S_TRAP);
    assign trap_cause_o = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_beta_useq.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_useq
// Brief    : Directed self-checking bench for beta_useq with PC/micro-address
//            scoreboards.
// Revision : 1.0
// ============================================================================
module tb_beta_useq;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] ir_o;
    logic [31:0] pc_o;
    logic [8:0]  cu_addr_i = '0;
    logic        invalid_i = 1'b0;
    logic [12:0] urom_addr_o;
    logic        exec_o;
    logic        uw_last_i = 1'b0;
    logic        uw_mem_i = 1'b0;
    logic        dmem_done_i = 1'b0;
    logic        pc_load_i = 1'b0;
    logic [31:0] pc_target_i = '0;
    logic        trap_o;
    logic [1:0]  trap_cause_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] q_pc[$];
    logic [12:0] q_urom[$];

    beta_useq #(.XLEN(32), .USTEP_W(4), .RESET_PC(32'h0)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .ir_o          (ir_o),
        .pc_o          (pc_o),
        .cu_addr_i     (cu_addr_i),
        .invalid_i     (invalid_i),
        .urom_addr_o   (urom_addr_o),
        .exec_o        (exec_o),
        .uw_last_i     (uw_last_i),
        .uw_mem_i      (uw_mem_i),
        .dmem_done_i   (dmem_done_i),
        .pc_load_i     (pc_load_i),
        .pc_target_i   (pc_target_i),
        .trap_o        (trap_o),
        .trap_cause_o  (trap_cause_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_uw();
        uw_last_i   = 1'b0;
        uw_mem_i    = 1'b0;
        dmem_done_i = 1'b0;
        pc_load_i   = 1'b0;
        pc_target_i = '0;
    endtask

    task automatic do_reset();
        rstn_i        = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        invalid_i     = 1'b0;
        cu_addr_i     = '0;
        clear_uw();
        q_pc.delete();
        q_urom.delete();
        repeat (2) tick();
        rstn_i = 1'b1;
        q_pc.push_back(32'h0);
    endtask

    // Fetch one instruction, optionally withholding gnt, then run DECODE.
    task automatic do_fetch(input logic [31:0] instr, input int gnt_wait,
                            input logic [8:0] cu, input logic inv);
        logic [31:0] a0;
        int          budget;
        budget = 0;
        while (!imem_req_o && budget < 20) begin
            tick();
            budget++;
        end
        chk("req_seen", imem_req_o, 1'b1);
        if (q_pc.size() != 0) chk("fetch_addr", imem_addr_o, q_pc.pop_front());
        a0 = imem_addr_o;
        imem_gnt_i = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = 32'hDEAD_BEEF;
            tick();
            chk("req_held", imem_req_o, 1'b1);
            chk("addr_stable", imem_addr_o, a0);
        end
        imem_rvalid_i = 1'b0;
        imem_gnt_i    = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        chk("fwait_req", imem_req_o, 1'b0);
        chk("fwait_exec", exec_o, 1'b0);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = instr;
        tick();
        imem_rvalid_i = 1'b0;
        chk("decode_ir", ir_o, instr);
        chk("decode_exec", exec_o, 1'b0);
        cu_addr_i = cu;
        invalid_i = inv;
        tick();
        invalid_i = 1'b0;
    endtask

    task automatic uw_cycle(input logic last, input logic mem, input logic done,
                            input logic load, input logic [31:0] tgt);
        uw_last_i   = last;
        uw_mem_i    = mem;
        dmem_done_i = done;
        pc_load_i   = load;
        pc_target_i = tgt;
        chk("exec_on", exec_o, 1'b1);
        if (q_urom.size() != 0) chk("urom_addr", urom_addr_o, q_urom.pop_front());
        tick();
        clear_uw();
    endtask

    initial begin
        // 1: reset values, first fetch timing, simple retire
        do_reset();
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_exec", exec_o, 1'b0);
        chk("rst_trap", trap_o, 1'b0);
        chk("rst_cause", trap_cause_o, 2'd0);
        chk("rst_ir", ir_o, 32'h0000_0013);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_urom", urom_addr_o, 13'h0);
        tick();
        chk("req_cycle1", imem_req_o, 1'b1);
        do_fetch(32'h0050_0093, 0, 9'h010, 1'b0);
        q_urom.push_back({9'h010, 4'd0});
        q_pc.push_back(32'h4);
        uw_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t1_pc", pc_o, 32'h4);
        chk("t1_exec_off", exec_o, 1'b0);

        // 2: gnt withheld three cycles, stray rvalid in FETCH ignored
        do_fetch(32'h0010_8113, 3, 9'h020, 1'b0);
        q_urom.push_back({9'h020, 4'd0});
        q_pc.push_back(32'h8);
        uw_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t2_pc", pc_o, 32'h8);

        // 3: three-word load program with a four-cycle memory access
        do_fetch(32'h0000_A103, 0, 9'h030, 1'b0);
        q_urom.push_back({9'h030, 4'd0});
        for (int i = 0; i < 4; i++) q_urom.push_back({9'h030, 4'd1});
        q_urom.push_back({9'h030, 4'd2});
        q_pc.push_back(32'hC);
        uw_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) uw_cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        uw_cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("t3_pc_before", pc_o, 32'h8);
        uw_cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t3_pc", pc_o, 32'hC);
        chk("t3_q_empty", q_urom.size(), 0);

        // 4: stalled last word does not retire; taken branch; misaligned branch traps
        do_fetch(32'h1000_0063, 0, 9'h040, 1'b0);
        q_urom.push_back({9'h040, 4'd0});
        q_urom.push_back({9'h040, 4'd0});
        uw_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h100);
        chk("t4_stall_pc", pc_o, 32'hC);
        q_pc.push_back(32'h100);
        uw_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h100);
        chk("t4_pc", pc_o, 32'h100);
        do_fetch(32'h1000_0063, 0, 9'h040, 1'b0);
        uw_cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h102);
        chk("t4_trap", trap_o, 1'b1);
        chk("t4_cause", trap_cause_o, 2'd2);
        chk("t4_pc_frozen", pc_o, 32'h100);
        chk("t4_exec_off", exec_o, 1'b0);
        tick();
        chk("t4_no_req", imem_req_o, 1'b0);

        // 5: invalid instruction traps straight from DECODE
        do_reset();
        do_fetch(32'hFFFF_FFFF, 0, 9'h000, 1'b1);
        chk("t5_trap", trap_o, 1'b1);
        chk("t5_cause", trap_cause_o, 2'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t5_exec_off", exec_o, 1'b0);
            chk("t5_no_req", imem_req_o, 1'b0);
            tick();
        end
        chk("t5_ir", ir_o, 32'hFFFF_FFFF);

        // 6: runaway micro-program, then asynchronous reset mid-EXEC
        do_reset();
        do_fetch(32'h0050_0093, 0, 9'h050, 1'b0);
        for (int i = 0; i < 16; i++) q_urom.push_back({9'h050, 4'(i)});
        for (int i = 0; i < 16; i++) uw_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6_trap", trap_o, 1'b1);
        chk("t6_cause", trap_cause_o, 2'd3);
        chk("t6_pc", pc_o, 32'h0);

        do_reset();
        do_fetch(32'h0050_0093, 0, 9'h060, 1'b0);
        uw_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        uw_cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("t6_pre_exec", exec_o, 1'b1);
        rstn_i = 1'b0;
        #1;
        chk("arst_exec", exec_o, 1'b0);
        chk("arst_req", imem_req_o, 1'b0);
        chk("arst_trap", trap_o, 1'b0);
        chk("arst_cause", trap_cause_o, 2'd0);
        chk("arst_ir", ir_o, 32'h0000_0013);
        chk("arst_pc", pc_o, 32'h0);
        chk("arst_urom", urom_addr_o, 13'h0);
        tick();
        rstn_i = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
